// File: rtl/glitch_pulse_gen.sv
// Glitch sequencer: optional target reset, programmed delay, then a train of glitch pulses.
// Parameters are latched on the start strobe; all outputs are registered.
module glitch_pulse_gen #(
  parameter bit TARGET_RST_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic [15:0] reset_length_i,
  input  logic        pulse_en_i,
  input  logic        reset_en_i,
  output logic        glitch_o,
  output logic        target_rst_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {StIdle, StTrst, StDelay, StPulse, StSpace, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pulses_q, pulses_d;
  logic [15:0] delay_q, spacing_q;
  logic [7:0]  width_q, num_q;
  logic        glitch_q, trst_q, busy_q, done_q;

  logic        start, use_trst;
  logic [15:0] p_delay;
  logic [7:0]  p_width, p_num, w_eff;
  logic [15:0] w_load;
  state_e      post_state;
  logic [15:0] post_cnt;

  assign start    = pulse_en_i | reset_en_i;
  assign use_trst = reset_en_i && (reset_length_i != 16'd0);

  // In IDLE the live inputs are about to be latched, so decode from them directly.
  assign p_delay = (state_q == StIdle) ? delay_i      : delay_q;
  assign p_width = (state_q == StIdle) ? width_i      : width_q;
  assign p_num   = (state_q == StIdle) ? num_pulses_i : num_q;
  assign w_eff   = (p_width == 8'd0) ? 8'd1 : p_width;
  assign w_load  = {8'd0, w_eff - 8'd1};

  // Entry into the delay window, shared by a plain start and the end of target reset.
  always_comb begin
    post_state = StDone;
    post_cnt   = 16'd0;
    if (p_delay != 16'd0) begin
      post_state = StDelay;
      post_cnt   = p_delay - 16'd1;
    end else if (p_num != 8'd0) begin
      post_state = StPulse;
      post_cnt   = w_load;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pulses_d = p_num;
          if (use_trst) begin
            state_d = StTrst;
            cnt_d   = reset_length_i - 16'd1;
          end else begin
            state_d = post_state;
            cnt_d   = post_cnt;
          end
        end
      end
      StTrst: begin
        if (cnt_q == 16'd0) begin
          state_d = post_state;
          cnt_d   = post_cnt;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDelay: begin
        if (cnt_q == 16'd0) begin
          if (pulses_q != 8'd0) begin
            state_d = StPulse;
            cnt_d   = w_load;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 16'd0) begin
          pulses_d = pulses_q - 8'd1;
          if (pulses_q == 8'd1) begin
            state_d = StDone;
          end else if (spacing_q == 16'd0) begin
            state_d = StPulse;
            cnt_d   = w_load;
          end else begin
            state_d = StSpace;
            cnt_d   = spacing_q - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StSpace: begin
        if (cnt_q == 16'd0) begin
          state_d = StPulse;
          cnt_d   = w_load;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      pulses_q  <= 8'd0;
      delay_q   <= 16'd0;
      spacing_q <= 16'd0;
      width_q   <= 8'd0;
      num_q     <= 8'd0;
      glitch_q  <= 1'b0;
      trst_q    <= TARGET_RST_ACTIVE_LOW;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      if (state_q == StIdle && start) begin
        delay_q   <= delay_i;
        spacing_q <= pulse_spacing_i;
        width_q   <= width_i;
        num_q     <= num_pulses_i;
      end
      glitch_q <= (state_d == StPulse);
      trst_q   <= (state_d == StTrst) ^ TARGET_RST_ACTIVE_LOW;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

  assign glitch_o     = glitch_q;
  assign target_rst_o = trst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Self-checking bench for glitch_pulse_gen: expected waveforms are built as per-cycle
// schedules from the sequence rules and compared against the DUT every cycle.
module tb_glitch_pulse_gen;

  localparam bit ActiveLow = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] delay_i, pulse_spacing_i, reset_length_i;
  logic [7:0]  width_i, num_pulses_i;
  logic        pulse_en_i, reset_en_i;
  logic        glitch_o, target_rst_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  glitch_pulse_gen #(.TARGET_RST_ACTIVE_LOW(ActiveLow)) dut (
    .clk             (clk),
    .rst             (rst),
    .delay_i         (delay_i),
    .width_i         (width_i),
    .num_pulses_i    (num_pulses_i),
    .pulse_spacing_i (pulse_spacing_i),
    .reset_length_i  (reset_length_i),
    .pulse_en_i      (pulse_en_i),
    .reset_en_i      (reset_en_i),
    .glitch_o        (glitch_o),
    .target_rst_o    (target_rst_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic trst_level(input bit asserted);
    return asserted ? ~ActiveLow : ActiveLow;
  endfunction

  task automatic scramble();
    delay_i         = 16'($urandom);
    width_i         = 8'($urandom);
    num_pulses_i    = 8'($urandom);
    pulse_spacing_i = 16'($urandom);
    reset_length_i  = 16'($urandom);
  endtask

  // strobe: 0 pulse_en, 1 reset_en, 2 both. perturb: cycle in which both strobes are pulsed.
  // abort_at: cycle in which rst is driven high (0 = never).
  task automatic run_seq(input string name, input int strobe, input int d, input int w,
                         input int n, input int sp, input int l, input int perturb,
                         input int abort_at);
    logic [3:0] exp_q[$];
    logic [3:0] exp_v, obs, idle_v;
    logic       lo, hi;
    int         total;
    lo = trst_level(1'b0);
    hi = trst_level(1'b1);
    idle_v = {1'b0, lo, 2'b00};
    if (strobe != 0 && l != 0) repeat (l) exp_q.push_back({1'b0, hi, 2'b10});
    repeat (d) exp_q.push_back({1'b0, lo, 2'b10});
    for (int p = 0; p < n; p++) begin
      repeat ((w == 0) ? 1 : w) exp_q.push_back({1'b1, lo, 2'b10});
      if (p != n - 1) repeat (sp) exp_q.push_back({1'b0, lo, 2'b10});
    end
    exp_q.push_back({1'b0, lo, 2'b11});
    total = exp_q.size();

    delay_i         = 16'(d);
    width_i         = 8'(w);
    num_pulses_i    = 8'(n);
    pulse_spacing_i = 16'(sp);
    reset_length_i  = 16'(l);
    pulse_en_i      = (strobe != 1);
    reset_en_i      = (strobe != 0);
    for (int k = 1; k <= total + 2; k++) begin
      @(posedge clk);
      #1;
      if (abort_at > 0 && k > abort_at) exp_v = idle_v;
      else if (k <= total)              exp_v = exp_q[k-1];
      else                              exp_v = idle_v;
      obs = {glitch_o, target_rst_o, busy_o, done_o};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: glitch/trst/busy/done got %b required %b",
                 name, k, obs, exp_v);
      end
      pulse_en_i = 1'b0;
      reset_en_i = 1'b0;
      rst        = 1'b0;
      scramble();
      if (k == perturb) begin
        pulse_en_i = 1'b1;
        reset_en_i = 1'b1;
      end
      if (k == abort_at) rst = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      obs = {glitch_o, target_rst_o, busy_o, done_o};
      checks++;
      if (obs !== {1'b0, trst_level(1'b0), 2'b00}) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got %b required %b", k, obs,
                 {1'b0, trst_level(1'b0), 2'b00});
      end
    end
    rst = 1'b0;
    scramble();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      obs = {glitch_o, target_rst_o, busy_o, done_o};
      checks++;
      if (obs !== {1'b0, trst_level(1'b0), 2'b00}) begin
        errors++;
        $display("FAIL idle_no_strobe cycle %0d: got %b required %b", k, obs,
                 {1'b0, trst_level(1'b0), 2'b00});
      end
    end
  endtask

  task automatic test_basic();
    run_seq("train_d3_w2_n3_s4", 0, 3, 2, 3, 4, 0, 0, 0);
    run_seq("trst5_then_pulse",  1, 0, 1, 1, 0, 5, 0, 0);
    run_seq("merged_spacing0",   0, 0, 2, 3, 0, 0, 0, 0);
    run_seq("no_pulses_d2",      0, 2, 3, 0, 1, 0, 0, 0);
    run_seq("width0_as_1",       0, 0, 0, 1, 0, 0, 0, 0);
    run_seq("n0_d0_done_next",   0, 0, 1, 0, 0, 0, 0, 0);
    run_seq("trst_len0",         1, 2, 1, 2, 1, 0, 0, 0);
    run_seq("both_strobes",      2, 1, 2, 2, 2, 3, 0, 0);
  endtask

  task automatic test_ignore_strobes();
    run_seq("ignore_mid_strobe", 0, 3, 2, 3, 4, 0, 6, 0);
  endtask

  task automatic test_mid_reset();
    run_seq("abort_in_trst",    1, 0, 1, 1, 0, 5, 0, 3);
    run_seq("run_after_abort",  0, 3, 2, 3, 4, 0, 0, 0);
    run_seq("abort_in_pulse",   0, 1, 4, 2, 1, 0, 0, 3);
  endtask

  task automatic test_back_to_back();
    run_seq("strobe_on_done",   0, 0, 2, 3, 0, 0, 7, 0);
    run_seq("next_after_done",  1, 1, 1, 2, 1, 2, 0, 0);
  endtask

  task automatic test_long_delay();
    run_seq("delay_ffff", 0, 65535, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int s, d, w, n, sp, l, pert;
    for (int i = 0; i < 25; i++) begin
      s    = int'($urandom_range(2, 0));
      d    = int'($urandom_range(6, 0));
      w    = int'($urandom_range(4, 0));
      n    = int'($urandom_range(4, 0));
      sp   = int'($urandom_range(3, 0));
      l    = int'($urandom_range(4, 0));
      pert = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 1)) : 0;
      run_seq($sformatf("random_%0d", i), s, d, w, n, sp, l, pert, 0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    pulse_en_i      = 1'b0;
    reset_en_i      = 1'b0;
    delay_i         = 16'd0;
    width_i         = 8'd0;
    num_pulses_i    = 8'd0;
    pulse_spacing_i = 16'd0;
    reset_length_i  = 16'd0;
    test_reset();
    test_basic();
    test_ignore_strobes();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_long_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
